range_stream_source: RTL and testbench

Burst generator that drives the sample stream consumed by the range-measurement block: it frames a pseudo-random sequence of samples with `go` and `finish` and computes the range the consumer must report. Its outputs connect directly to the consumer's data/go/finish inputs. It serves as an on-chip self-test source and as the bench's reference initiator. Each burst is described by a seed and a sample count; `done` and `expected_range` let the consumer's `range` output be checked in place.

---
 rtl/range_stream_source.sv | 106 ++++++++++
 tb/tb_range_stream_source.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/range_stream_source.sv
// Burst generator for the range-measurement consumer: emits a Galois-LFSR
// sample burst framed by go/finish and reports the max-min range it produced.
module range_stream_source #(
  parameter int               WIDTH = 10,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] expected_range
);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] seed_fix;
  logic             accept;
  logic             last_sample;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : '0);
  endfunction

  // A zero seed would lock the LFSR at zero forever.
  assign seed_fix    = (seed == '0) ? WIDTH'(1) : seed;
  assign accept      = (state_q == IDLE) && start && (count != '0);
  assign last_sample = (remaining_q == CNT_W'(1)) || abort;
  assign lfsr_d      = lfsr_step(lfsr_q);
  assign min_d       = (lfsr_q < min_q) ? lfsr_q : min_q;
  assign max_d       = (lfsr_q > max_q) ? lfsr_q : max_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      remaining_q    <= '0;
      data_out       <= '0;
      go             <= 1'b0;
      finish         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      expected_range <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state_q     <= STREAM;
            remaining_q <= count;
            data_out    <= seed_fix;
            go          <= 1'b1;
            busy        <= 1'b1;
          end
        end
        STREAM: begin
          remaining_q <= remaining_q - CNT_W'(1);
          if (last_sample) begin
            // data_out keeps the final sample through FINISH.
            state_q <= FINISH;
            go      <= 1'b0;
            finish  <= 1'b1;
          end else begin
            data_out <= lfsr_d;
          end
        end
        FINISH: begin
          state_q        <= DONE;
          finish         <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b1;
          expected_range <= max_q - min_q;
        end
        default: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Sample generator and running extremes; only meaningful during a burst.
  always_ff @(posedge clock) begin
    if (accept) begin
      lfsr_q <= seed_fix;
      min_q  <= '1;
      max_q  <= '0;
    end else if (state_q == STREAM) begin
      lfsr_q <= lfsr_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

endmodule

// File: tb/tb_range_stream_source.sv
// Directed and randomized bursts against a sequence-level reference model.
module tb_range_stream_source;

  localparam int W  = 10;
  localparam int CW = 8;
  localparam int TAPS_I = 'h240;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [W-1:0]  seed;
  logic [CW-1:0] count;
  logic [W-1:0]  data_out;
  logic          go;
  logic          finish;
  logic          busy;
  logic          done;
  logic [W-1:0]  expected_range;

  int total = 0;
  int bad   = 0;

  range_stream_source #(.WIDTH(W), .CNT_W(CW), .TAPS(10'h240)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .seed(seed), .count(count), .data_out(data_out), .go(go),
    .finish(finish), .busy(busy), .done(done), .expected_range(expected_range)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Polynomial sequence: halve, and fold in the tap mask when the value was odd.
  function automatic int next_sample(input int x);
    return (x / 2) ^ (((x % 2) == 1) ? TAPS_I : 0);
  endfunction

  task automatic run_burst(input int sd, input int n, input int abort_at,
                           input int pulse_at, input string name);
    int smp[$];
    int s, m, lo, hi;
    s  = (sd == 0) ? 1 : sd;
    m  = (abort_at >= 0 && abort_at < n) ? abort_at + 1 : n;
    lo = (1 << W) - 1;
    hi = 0;
    smp = {};
    for (int i = 0; i < m; i++) begin
      smp.push_back(s);
      if (s < lo) lo = s;
      if (s > hi) hi = s;
      s = next_sample(s);
    end
    seed  = W'(sd);
    count = CW'(n);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seed  = W'($urandom);
    count = CW'($urandom);
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.go[%0d]", name, i), go, 1);
      check($sformatf("%s.data[%0d]", name, i), data_out, smp[i]);
      check($sformatf("%s.fin[%0d]", name, i), finish, 0);
      check($sformatf("%s.busy[%0d]", name, i), busy, 1);
      if (i == abort_at) abort = 1'b1;
      if (i == pulse_at) start = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      start = 1'b0;
    end
    check({name, ".finish"}, finish, 1);
    check({name, ".fin_go"}, go, 0);
    check({name, ".fin_busy"}, busy, 1);
    check({name, ".fin_data"}, data_out, smp[m-1]);
    check({name, ".fin_done"}, done, 0);
    @(negedge clock);
    check({name, ".done"}, done, 1);
    check({name, ".range"}, expected_range, hi - lo);
    check({name, ".done_busy"}, busy, 0);
    check({name, ".done_go"}, go, 0);
    check({name, ".done_fin"}, finish, 0);
    @(negedge clock);
    check({name, ".idle_done"}, done, 0);
    check({name, ".idle_go"}, go, 0);
    check({name, ".idle_busy"}, busy, 0);
    check({name, ".idle_range"}, expected_range, hi - lo);
  endtask

  initial begin
    int sd, n, ab;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    seed  = '0;
    count = '0;
    #2;
    check("rst.go", go, 0);
    check("rst.finish", finish, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.data", data_out, 0);
    check("rst.range", expected_range, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_burst(5, 1, -1, -1, "s5n1");
    run_burst(1, 3, -1, -1, "s1n3");
    run_burst(0, 3, -1, -1, "s0n3");

    seed  = 10'd7;
    count = '0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("cnt0.busy[%0d]", i), busy, 0);
      check($sformatf("cnt0.go[%0d]", i), go, 0);
      check($sformatf("cnt0.done[%0d]", i), done, 0);
    end
    start = 1'b0;
    @(negedge clock);

    run_burst(1, 3, -1, 1, "pulse");
    @(negedge clock);
    check("pulse.no_second_go", go, 0);
    check("pulse.no_second_busy", busy, 0);

    run_burst(1, 8, 1, -1, "abort");

    seed  = 10'd1;
    count = 8'd8;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("mid.data0", data_out, 1);
    @(negedge clock);
    check("mid.data1", data_out, 576);
    reset = 1'b1;
    #1;
    check("mid.go", go, 0);
    check("mid.finish", finish, 0);
    check("mid.busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mid.no_done[%0d]", i), done, 0);
      check($sformatf("mid.no_go[%0d]", i), go, 0);
      @(negedge clock);
    end
    run_burst(1, 3, -1, -1, "post_rst");

    for (int k = 0; k < 10; k++) begin
      sd = int'($urandom_range(0, 1023));
      n  = int'($urandom_range(1, 12));
      ab = int'($urandom_range(0, 2 * n));
      if (ab >= n) ab = -1;
      run_burst(sd, n, ab, -1, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
